alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 4..16).
REQ-002 Port: clk  input  1  rising-edge clock; single clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: in_valid  input  1  request present on op/a/b.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: op  input  4  operation code.
REQ-007 Port: a  input  WIDTH  operand A, unsigned.
REQ-008 Port: b  input  WIDTH  operand B, unsigned.
REQ-009 Port: out_valid  output  1  result/flags valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port: result  output  2*WIDTH  registered result.
REQ-012 Port: flag_zero  output  1  result == 0.
REQ-013 Port: flag_carry  output  1  ADD carry-out / SUB borrow (a < b); 0 for all other ops.
REQ-014 Port: flag_err  output  1  DIV/REM with b == 0, or undefined op.

Function
REQ-015 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 MUL a*b; 3 DIV a/b; 4 AND; 5 OR; 6 NOTA ~a; 7 NOTB ~b; 8 SQA a*a; 9 SQB b*b; 10 LT; 11 EQ; 12 GT; 13 REM a%b; 14-15 undefined.
REQ-016 Width rules: ADD = zero-extended WIDTH+1-bit sum; SUB = WIDTH-bit difference mod 2^WIDTH, upper bits 0; MUL/SQA/SQB = full 2*WIDTH product; logic ops WIDTH bits, upper bits 0.
REQ-017 LT/EQ/GT: result all ones (2*WIDTH bits) when true, all zeros when false.
REQ-018 Handshake: request accepted on a rising edge where in_valid && in_ready; op/a/b captured into internal registers that cycle.
REQ-019 Result handshake: result transferred on a rising edge where out_valid && out_ready; result, flags and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-020 FSM states: IDLE, EXEC, DIV, DONE; in_ready = 1 only in IDLE.
REQ-021 IDLE -> EXEC on accept of ops 0-2, 4-12, 14, 15; IDLE -> DIV on accept of op 3 or 13 with b != 0; IDLE -> EXEC on accept of op 3 or 13 with b == 0.
REQ-022 EXEC: compute from captured operands, register result/flags, -> DONE; out_valid rises 2 cycles after the accept edge (accept edge N, out_valid high after edge N+1... counted: visible in cycle following edge N+1).
REQ-023 DIV: restoring shift-subtract, one quotient bit per cycle, exactly WIDTH cycles, then -> DONE; DIV result = quotient, REM result = remainder, both zero-extended.
REQ-024 DONE: out_valid = 1; on out_valid && out_ready -> IDLE, out_valid deasserts the next cycle; no back-to-back accept in the same cycle as result transfer.
REQ-025 Divide by zero: result = all ones, flag_err = 1, flag_zero = 0, latency as EXEC.
REQ-026 Undefined op (14, 15): result = 0, flag_err = 1, flag_zero = 1, latency as EXEC.
REQ-027 in_valid while not in IDLE is ignored; op/a/b changes after accept do not affect the in-flight operation.
REQ-028 flag_zero computed over the full 2*WIDTH result.

Reset
REQ-029 rst=1 on a clock edge forces IDLE, out_valid=0, result=0, flag_zero=0, flag_carry=0, flag_err=0, divider state cleared; in_ready=1 from the first cycle after rst deasserts.
REQ-030 Reset asserted mid-DIV or in DONE aborts the operation; no result is ever presented for it.
REQ-031 A request presented while rst=1 is not accepted.

Verification (WIDTH=8)
REQ-032 ADD a=0xFF b=0x01 -> result=0x0100, carry=0, zero=0, err=0; SUB a=0x03 b=0x05 -> result=0x00FE, carry=1.
REQ-033 MUL a=0xFF b=0xFF -> result=0xFE01; SQB b=0x10 -> 0x0100; GT a=9 b=3 -> 0xFFFF; EQ a=4 b=5 -> 0x0000, zero=1.
REQ-034 DIV a=200 b=7 -> result=28 with out_valid exactly WIDTH+2 cycles after accept; REM same operands -> 4.
REQ-035 DIV a=5 b=0 -> result=0xFFFF, err=1, EXEC latency; op=15 -> result=0, err=1, zero=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-037 Assert rst on 3rd DIV cycle -> next cycle out_valid=0, all outputs 0, in_ready=1 after release, next request completes correctly.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request and result handshake.
// Single-cycle ops go through EXEC; DIV/REM use a restoring divider.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 flag_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StExec, StDiv, StDone} state_e;

  state_e               state_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     rem_q, quo_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 zero_q, carry_q, err_q, out_valid_q;

  logic [2*WIDTH-1:0]   alu_res, a_x, b_x, div_res;
  logic [WIDTH:0]       sum;
  logic                 alu_carry, alu_err;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     trial;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt;

  assign in_ready   = (state_q == StIdle) && !rst;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_err   = err_q;

  assign a_x = {{WIDTH{1'b0}}, a_q};
  assign b_x = {{WIDTH{1'b0}}, b_q};
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      4'd0: begin
        alu_res   = {{(WIDTH-1){1'b0}}, sum};
        alu_carry = sum[WIDTH];
      end
      4'd1: begin
        alu_res   = {{WIDTH{1'b0}}, a_q - b_q};
        alu_carry = a_q < b_q;
      end
      4'd2:  alu_res = a_x * b_x;
      // DIV/REM only reach EXEC when the divisor is zero
      4'd3, 4'd13: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
      4'd4:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
      4'd5:  alu_res = {{WIDTH{1'b0}}, a_q | b_q};
      4'd6:  alu_res = {{WIDTH{1'b0}}, ~a_q};
      4'd7:  alu_res = {{WIDTH{1'b0}}, ~b_q};
      4'd8:  alu_res = a_x * a_x;
      4'd9:  alu_res = b_x * b_x;
      4'd10: alu_res = {(2*WIDTH){a_q < b_q}};
      4'd11: alu_res = {(2*WIDTH){a_q == b_q}};
      4'd12: alu_res = {(2*WIDTH){a_q > b_q}};
      default: alu_err = 1'b1;
    endcase
  end

  // One restoring step: shift the next dividend bit in, subtract if it fits
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, b_q};
    if (trial[WIDTH+1]) begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign div_res = {{WIDTH{1'b0}}, (op_q == 4'd3) ? quo_q : rem_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            rem_q <= '0;
            quo_q <= a;
            cnt_q <= '0;
            if ((op == 4'd3 || op == 4'd13) && b != '0) state_q <= StDiv;
            else                                        state_q <= StExec;
          end
        end
        StExec: begin
          result_q    <= alu_res;
          zero_q      <= (alu_res == '0);
          carry_q     <= alu_carry;
          err_q       <= alu_err;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDiv: begin
          // WIDTH shift-subtract steps, then one cycle to register the answer
          if (cnt_q == CntW'(WIDTH)) begin
            result_q    <= div_res;
            zero_q      <= (div_res == '0);
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
